wb_accel_slot_fabric: RTL and testbench
=======================================

Name: wb_accel_slot_fabric

Overview:
Parametrised Wishbone slave fabric that replaces the single hard-wired accelerator hookup. It fans one Caravel Wishbone slave port out to NUM_SLOTS accelerator slots, decoding the slot from address bits. Each slot gets a per-slot enable, a bus-timeout watchdog and sticky error status. Status is reported through a local CSR bank and an interrupt.

Parameters:
NUM_SLOTS, 4, number of accelerator slots; must be ≤ 2^IDX_W − 1
IDX_W, 3, slot-index field width; index 2^IDX_W − 1 selects the local CSR bank
BASE_ADDR, 32'h3000_0000, window base; a hit is adr[31:SLOT_SHIFT+IDX_W] == BASE_ADDR[31:SLOT_SHIFT+IDX_W]
SLOT_SHIFT, 16, LSB position of the slot-index field
TIMEOUT, 256, cycles allowed for a slot ack before the fabric aborts; ≥ 2
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout or on a disabled/absent slot

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous, active-high reset
wbs_cyc_i  in  1  master cycle
wbs_stb_i  in  1  master strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  ack, single-cycle pulse
wbs_dat_o  out  32  read data, valid while ack is high
s_cyc_o  out  NUM_SLOTS  per-slot cycle, one-hot or zero
s_stb_o  out  NUM_SLOTS  per-slot strobe, one-hot or zero
s_we_o  out  1  latched we
s_sel_o  out  4  latched sel
s_adr_o  out  32  latched address
s_dat_o  out  32  latched write data
s_ack_i  in  NUM_SLOTS  per-slot ack
s_dat_i  in  32*NUM_SLOTS  per-slot read data; slot k occupies [32k+31:32k]
irq_o  out  1  registered OR of timeout-status bits

Behaviour:
- Reset: FSM=IDLE; wbs_ack_o=0; wbs_dat_o=0; s_cyc_o=s_stb_o=0; s_we_o=0; s_sel_o=0; s_adr_o=0; s_dat_o=0; slot_en = all ones (NUM_SLOTS bits); to_status=0; to_addr=0; watchdog=0; irq_o=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, cyc&stb&window hit, no ack pending:
  - Latch adr/dat/we/sel into the s_* outputs.
  - idx = adr[SLOT_SHIFT +: IDX_W].
  - idx < NUM_SLOTS and slot_en[idx]=1: go to ACCESS; s_cyc_o[idx]=s_stb_o[idx]=1 from the next cycle.
  - idx < NUM_SLOTS and disabled, or NUM_SLOTS ≤ idx < 2^IDX_W−1: go to RESP; reads return ERR_DATA; writes are dropped.
  - idx == 2^IDX_W−1: CSR access, performed in this cycle; go to RESP.
- Window miss: ignored; no ack, no state change.
- ACCESS:
  - Watchdog increments every cycle.
  - s_ack_i[idx]=1: capture s_dat_i slice into wbs_dat_o; clear s_cyc/s_stb; go to RESP.
  - Watchdog == TIMEOUT−1 with no ack: clear s_cyc/s_stb; set to_status[idx]; to_addr = latched adr; wbs_dat_o = ERR_DATA; go to RESP.
  - If ack and timeout coincide, the ack wins.
  - Acks from non-selected slots are ignored.
- RESP: wbs_ack_o=1 for exactly one cycle; then IDLE. Watchdog clears. wbs_dat_o returns to 0 in IDLE.
- Master abort: cyc_i drops while in ACCESS → clear s_cyc/s_stb next cycle; return to IDLE; no wbs_ack_o; no status update.
- Latency (request accepted in cycle 0):
  - Slot strobe asserts in cycle 1.
  - Slot ack in cycle k → wbs_ack_o in cycle k+1.
  - CSR, disabled or absent slot → wbs_ack_o in cycle 1.
  - Timeout → wbs_ack_o in cycle TIMEOUT+1.
- CSR bank (byte offset = adr[7:0]; other offsets read 0, writes ignored; wbs_sel_i ignored):
  - 0x00 slot_en: R/W, NUM_SLOTS bits.
  - 0x04 to_status: read; write-1-to-clear. A set and a clear of the same bit in the same cycle leaves the bit set.
  - 0x08 to_addr: RO.
  - 0x0C: RO, {16'(NUM_SLOTS), 8'(IDX_W), 8'h01 version}.
- irq_o = |to_status, registered (one-cycle delay).
- Reset mid-transaction: all state returns to reset values on the next edge; no ack is issued.

Test Plan:
- Read slot 2 (adr 0x3002_0010); slot acks 3 cycles after strobe with 0x1234_5678 → s_stb_o=4'b0100 in cycle 1; wbs_ack_o in cycle 5 with wbs_dat_o=0x1234_5678; s_adr_o=0x3002_0010.
- Write slot 1 with sel=4'b0011, data 0xA5A5_0000; slot acks on its first strobe cycle → s_we_o=1, s_sel_o=4'b0011; wbs_ack_o in cycle 2; exactly one ack pulse.
- Slot 3 never acks (TIMEOUT=256) → wbs_ack_o in cycle 257 with 0xDEAD_BEEF; to_status=4'b1000; to_addr=latched address; irq_o=1 one cycle after the status sets; write 0x8 to 0x3007_0004 → status 0, irq_o falls.
- Write 0xD to 0x3007_0000, then read slot 1 → ack in cycle 1 with ERR_DATA; s_stb_o stays 0. Read slot 5 (absent) → ERR_DATA. Read 0x3007_000C → 0x0004_0301.
- Master drops cyc in cycle 3 of a slot-0 access → s_cyc_o[0] low in cycle 4; no wbs_ack_o; to_status unchanged. Next access completes normally.
- Assert wb_rst_i during ACCESS → all outputs at reset values on the next edge; slot_en=4'b1111; no ack issued. Address 0x4000_0000 → no ack, FSM stays IDLE.

Source files
------------

// File: rtl/wb_accel_slot_fabric.sv
// Wishbone slave fabric: fans one Caravel slave port out to NUM_SLOTS accelerator
// slots, with per-slot enables, a bus-timeout watchdog, sticky timeout status,
// a local CSR bank at the top slot index and a timeout interrupt.
module wb_accel_slot_fabric #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned IDX_W      = 3,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned SLOT_SHIFT = 16,
  parameter int unsigned TIMEOUT    = 256,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [NUM_SLOTS-1:0]      s_cyc_o,
  output logic [NUM_SLOTS-1:0]      s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  input  logic [NUM_SLOTS-1:0]      s_ack_i,
  input  logic [32*NUM_SLOTS-1:0]   s_dat_i,
  output logic                      irq_o
);

  localparam int unsigned HIT_LSB = SLOT_SHIFT + IDX_W;
  localparam int unsigned WD_W    = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] CSR_IDX = '1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [31:0]      CSR_ID  = {16'(NUM_SLOTS), 8'(IDX_W), 8'h01};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]           r_state,     w_state_nxt;
  logic                 r_ack,       w_ack_nxt;
  logic [31:0]          r_dat,       w_dat_nxt;
  logic [NUM_SLOTS-1:0] r_cyc,       w_cyc_nxt;
  logic                 r_we,        w_we_nxt;
  logic [3:0]           r_sel,       w_sel_nxt;
  logic [31:0]          r_adr,       w_adr_nxt;
  logic [31:0]          r_wdat,      w_wdat_nxt;
  logic [NUM_SLOTS-1:0] r_slot_en,   w_slot_en_nxt;
  logic [NUM_SLOTS-1:0] r_to_status, w_to_status_nxt;
  logic [31:0]          r_to_addr,   w_to_addr_nxt;
  logic [WD_W-1:0]      r_wd,        w_wd_nxt;
  logic                 r_irq,       w_irq_nxt;

  logic                 w_hit;
  logic                 w_req;
  logic [IDX_W-1:0]     w_idx;
  logic [NUM_SLOTS-1:0] w_req_oh;
  logic                 w_slot_ok;
  logic                 w_slot_ack;
  logic [31:0]          w_slot_dat;
  logic [31:0]          w_csr_rdata;
  logic [NUM_SLOTS-1:0] w_to_set;
  logic [NUM_SLOTS-1:0] w_to_clr;

  assign w_hit      = (wbs_adr_i[31:HIT_LSB] == BASE_ADDR[31:HIT_LSB]);
  assign w_idx      = wbs_adr_i[SLOT_SHIFT +: IDX_W];
  assign w_req      = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
  assign w_slot_ok  = |(w_req_oh & r_slot_en);
  assign w_slot_ack = |(s_ack_i & r_cyc);

  // One-hot slot decode of the request index (zero for absent slots and CSR)
  always_comb begin
    w_req_oh = '0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      if (w_idx == IDX_W'(k)) w_req_oh[k] = 1'b1;
    end
  end

  // Read-data slice of the slot currently being strobed
  always_comb begin
    w_slot_dat = '0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      if (r_cyc[k]) w_slot_dat = s_dat_i[32*k +: 32];
    end
  end

  // Local CSR read mux, byte offset in the low address byte
  always_comb begin
    w_csr_rdata = '0;
    case (wbs_adr_i[7:0])
      8'h00:   w_csr_rdata = 32'(r_slot_en);
      8'h04:   w_csr_rdata = 32'(r_to_status);
      8'h08:   w_csr_rdata = r_to_addr;
      8'h0C:   w_csr_rdata = CSR_ID;
      default: w_csr_rdata = '0;
    endcase
  end

  // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_ack_nxt       = 1'b0;
    w_dat_nxt       = r_dat;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_adr_nxt       = r_adr;
    w_wdat_nxt      = r_wdat;
    w_slot_en_nxt   = r_slot_en;
    w_to_addr_nxt   = r_to_addr;
    w_wd_nxt        = r_wd;
    w_irq_nxt       = |r_to_status;
    w_to_set        = '0;
    w_to_clr        = '0;

    case (r_state)
      ST_IDLE: begin
        w_dat_nxt = '0;
        w_wd_nxt  = '0;
        if (w_req) begin
          w_we_nxt   = wbs_we_i;
          w_sel_nxt  = wbs_sel_i;
          w_adr_nxt  = wbs_adr_i;
          w_wdat_nxt = wbs_dat_i;
          if (w_idx == CSR_IDX) begin
            w_state_nxt = ST_RESP;
            w_ack_nxt   = 1'b1;
            if (wbs_we_i) begin
              case (wbs_adr_i[7:0])
                8'h00:   w_slot_en_nxt = wbs_dat_i[NUM_SLOTS-1:0];
                8'h04:   w_to_clr      = wbs_dat_i[NUM_SLOTS-1:0];
                default: w_to_clr      = '0;
              endcase
            end else begin
              w_dat_nxt = w_csr_rdata;
            end
          end else if (w_slot_ok) begin
            w_state_nxt = ST_ACCESS;
            w_cyc_nxt   = w_req_oh;
          end else begin
            // Disabled or absent slot: immediate error response, writes dropped
            w_state_nxt = ST_RESP;
            w_ack_nxt   = 1'b1;
            w_dat_nxt   = wbs_we_i ? 32'h0 : ERR_DATA;
          end
        end
      end

      ST_ACCESS: begin
        w_wd_nxt = r_wd + WD_W'(1);
        if (!wbs_cyc_i) begin
          // Master abort: release the slot silently
          w_cyc_nxt   = '0;
          w_wd_nxt    = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_slot_ack) begin
          w_dat_nxt   = w_slot_dat;
          w_cyc_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_wd == WD_LAST) begin
          w_dat_nxt     = ERR_DATA;
          w_cyc_nxt     = '0;
          w_ack_nxt     = 1'b1;
          w_to_set      = r_cyc;
          w_to_addr_nxt = r_adr;
          w_state_nxt   = ST_RESP;
        end
      end

      ST_RESP: begin
        w_dat_nxt   = '0;
        w_wd_nxt    = '0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_cyc_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A set in the same cycle as a write-1-to-clear keeps the bit set
    w_to_status_nxt = (r_to_status & ~w_to_clr) | w_to_set;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_cyc       <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_wdat      <= '0;
      r_slot_en   <= '1;
      r_to_status <= '0;
      r_to_addr   <= '0;
      r_wd        <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_dat       <= w_dat_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_adr       <= w_adr_nxt;
      r_wdat      <= w_wdat_nxt;
      r_slot_en   <= w_slot_en_nxt;
      r_to_status <= w_to_status_nxt;
      r_to_addr   <= w_to_addr_nxt;
      r_wd        <= w_wd_nxt;
      r_irq       <= w_irq_nxt;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign s_cyc_o   = r_cyc;
  assign s_stb_o   = r_cyc;
  assign s_we_o    = r_we;
  assign s_sel_o   = r_sel;
  assign s_adr_o   = r_adr;
  assign s_dat_o   = r_wdat;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_wb_accel_slot_fabric.sv
// Scoreboard bench for wb_accel_slot_fabric: a master task issues requests and
// queues the expected response; a monitor pops and checks on every wbs_ack_o.
module tb_wb_accel_slot_fabric;

  localparam int NS    = 4;
  localparam int IW    = 3;
  localparam int SS    = 16;
  localparam int TO    = 256;
  localparam int NEVER = -1;
  localparam int CSR_SLOT = (1 << IW) - 1;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

  typedef struct {
    int          cyc;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             m_cyc, m_stb, m_we;
  logic [3:0]       m_sel;
  logic [31:0]      m_adr, m_wdat;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic             s_we_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic [NS-1:0]    s_ack_i = '0;
  logic [32*NS-1:0] s_dat_i = '0;
  logic             irq_o;

  int   cyc_cnt = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model state
  logic [NS-1:0] slot_en_m;
  logic [NS-1:0] to_status_m;
  logic [31:0]   to_addr_m;

  // Slot responder configuration
  int          slot_lat [NS];
  logic [31:0] slot_rdat[NS];
  int          slot_cnt [NS];
  bit          noise_en = 1'b0;

  wb_accel_slot_fabric #(
    .NUM_SLOTS(NS), .IDX_W(IW), .BASE_ADDR(BASE), .SLOT_SHIFT(SS),
    .TIMEOUT(TO), .ERR_DATA(ERR)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(m_cyc), .wbs_stb_i(m_stb), .wbs_we_i(m_we), .wbs_sel_i(m_sel),
    .wbs_adr_i(m_adr), .wbs_dat_i(m_wdat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [31:0] csr_model(input int off);
    case (off)
      0:       return 32'(slot_en_m);
      4:       return 32'(to_status_m);
      8:       return to_addr_m;
      12:      return 32'h0004_0301;
      default: return 32'h0;
    endcase
  endfunction

  task automatic csr_write_model(input int off, input logic [31:0] d);
    if (off == 0) slot_en_m = d[NS-1:0];
    else if (off == 4) to_status_m = to_status_m & ~d[NS-1:0];
  endtask

  // Slots: ack after a configured number of strobe cycles; idle slots emit noise acks
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NS; k++) begin
      if (s_stb_o[k]) begin
        slot_cnt[k]++;
        s_ack_i[k] = (slot_lat[k] >= 0) && (slot_cnt[k] == slot_lat[k] + 1);
        s_dat_i[32*k +: 32] = slot_rdat[k];
      end else begin
        slot_cnt[k] = 0;
        s_ack_i[k] = noise_en && ($urandom_range(3) == 0);
        s_dat_i[32*k +: 32] = $urandom;
      end
    end
  end

  // Monitor: every ack must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (wbs_ack_o === 1'b1) begin
      check("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("ack_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
        if (mon_e.chk) check("ack_data", wbs_dat_o, mon_e.dat);
      end
    end
  end

  // One master transaction; abort_at > 0 drops cyc in that cycle after acceptance
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input int lat, input logic [31:0] rd,
                        input int abort_at);
    exp_t          e;
    int            c0, idx, off, n, last_n;
    bit            hit, exp_ack, got;
    logic [NS-1:0] exp_stb;
    @(posedge clk); #1;
    c0      = cyc_cnt;
    hit     = ((a >> (SS + IW)) == (BASE >> (SS + IW)));
    idx     = int'((a >> SS) & 32'(CSR_SLOT));
    off     = int'(a & 32'hFF);
    exp_stb = '0;
    exp_ack = hit;
    e.cyc = 0; e.chk = 1'b0; e.dat = 32'h0;
    if (hit && idx == CSR_SLOT) begin
      e.cyc = c0 + 1; e.chk = !w; e.dat = csr_model(off);
      if (w) csr_write_model(off, d);
    end else if (hit && idx < NS && slot_en_m[idx]) begin
      slot_lat[idx]  = lat;
      slot_rdat[idx] = rd;
      exp_stb[idx]   = 1'b1;
      if (abort_at > 0) exp_ack = 1'b0;
      else if (lat >= 0 && lat <= TO - 1) begin
        e.cyc = c0 + 2 + lat; e.chk = !w; e.dat = rd;
      end else begin
        e.cyc = c0 + TO + 1; e.chk = 1'b1; e.dat = ERR;
        to_status_m[idx] = 1'b1;
        to_addr_m = a;
      end
    end else if (hit) begin
      e.cyc = c0 + 1; e.chk = !w; e.dat = ERR;
    end
    if (exp_ack) sb.push_back(e);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = a; m_we = w; m_wdat = d; m_sel = s;

    last_n = exp_ack ? TO + 8 : (abort_at > 0 ? abort_at + 3 : 4);
    got = 1'b0;
    n = 0;
    while (!got && n < last_n) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check("slot_stb", 32'(s_stb_o), 32'(exp_stb));
        if (hit) begin
          check("s_adr", s_adr_o, a);
          check("s_we", 32'(s_we_o), 32'(w));
          check("s_sel", 32'(s_sel_o), 32'(s));
          check("s_dat", s_dat_o, d);
        end
      end
      if (abort_at > 0 && n == abort_at) begin
        check("cyc_before_abort", 32'(s_cyc_o), 32'(exp_stb));
        m_cyc = 1'b0; m_stb = 1'b0;
      end
      if (abort_at > 0 && n == abort_at + 1) check("cyc_after_abort", 32'(s_cyc_o), 32'h0);
      if (wbs_ack_o) begin
        got = 1'b1;
        m_cyc = 1'b0; m_stb = 1'b0;
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    check("ack_seen", 32'(got), 32'(exp_ack));
    if (exp_ack && !got && sb.size() != 0) void'(sb.pop_front());
    @(posedge clk); #1;
    check("irq", 32'(irq_o), 32'(|to_status_m));
    check("dat_idle", wbs_dat_o, 32'h0);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc_cnt);
    $fatal(1, "global timeout");
  end

  initial begin
    int r, p, idx, lat, ab, off;
    logic w;
    logic [31:0] a, d;
    rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_sel = '0; m_adr = '0; m_wdat = '0;
    for (int k = 0; k < NS; k++) begin
      slot_lat[k] = NEVER; slot_rdat[k] = '0; slot_cnt[k] = 0;
    end
    slot_en_m = '1; to_status_m = '0; to_addr_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_stb", 32'(s_stb_o), 32'h0);
    check("rst_we", 32'(s_we_o), 32'h0);
    check("rst_sel", 32'(s_sel_o), 32'h0);
    check("rst_adr", s_adr_o, 32'h0);
    check("rst_sdat", s_dat_o, 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    rst = 1'b0;
    noise_en = 1'b1;

    // Directed scenarios
    do_req(32'h3002_0010, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, 0);
    do_req(32'h3001_0004, 1'b1, 32'hA5A5_0000, 4'b0011, 0, 32'h0, 0);
    do_req(32'h3003_0020, 1'b0, 32'h0, 4'hF, NEVER, 32'h0, 0);
    do_req(32'h3007_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_0008, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_0004, 1'b1, 32'h8, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_0000, 1'b1, 32'hD, 4'hF, 0, 32'h0, 0);
    do_req(32'h3001_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3005_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_000C, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_0000, 1'b1, 32'hF, 4'hF, 0, 32'h0, 0);
    do_req(32'h3000_0100, 1'b0, 32'h0, 4'hF, NEVER, 32'h0, 3);
    do_req(32'h3000_0104, 1'b0, 32'h0, 4'hF, 1, 32'hCAFE_0001, 0);
    do_req(32'h3000_0108, 1'b0, 32'h0, 4'hF, TO - 1, 32'h5A5A_1234, 0);
    do_req(32'h3002_0200, 1'b0, 32'h0, 4'hF, NEVER, 32'h0, 0);
    do_req(32'h3007_0000, 1'b1, 32'h7, 4'hF, 0, 32'h0, 0);

    // Reset during an outstanding slot access
    @(posedge clk); #1;
    slot_lat[0] = NEVER;
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h3000_0040; m_we = 1'b1;
    m_wdat = 32'h1111_2222; m_sel = 4'hF;
    @(posedge clk); #1;
    check("rst_mid_stb_before", 32'(s_stb_o), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    check("rst_mid_ack", 32'(wbs_ack_o), 32'h0);
    check("rst_mid_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_mid_adr", s_adr_o, 32'h0);
    check("rst_mid_we", 32'(s_we_o), 32'h0);
    check("rst_mid_sel", 32'(s_sel_o), 32'h0);
    check("rst_mid_sdat", s_dat_o, 32'h0);
    check("rst_mid_irq", 32'(irq_o), 32'h0);
    slot_en_m = '1; to_status_m = '0; to_addr_m = '0;

    do_req(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);
    do_req(32'h3007_0008, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(99);
      w = 1'($urandom_range(1));
      d = $urandom;
      if (r < 8) begin
        a = {4'h4 + 4'($urandom_range(3)), 28'($urandom)};
        do_req(a, w, d, 4'($urandom), NEVER, 32'h0, 0);
      end else if (r < 35) begin
        case ($urandom_range(5))
          0:       off = 0;
          1:       off = 4;
          2:       off = 8;
          3:       off = 12;
          4:       off = 16;
          default: off = 2;
        endcase
        a = {BASE[31:19], 3'(CSR_SLOT), 8'($urandom), 8'(off)};
        do_req(a, w, d, 4'($urandom), 0, 32'h0, 0);
      end else begin
        idx = $urandom_range(6);
        p   = $urandom_range(99);
        ab  = 0;
        if (p < 80) lat = $urandom_range(5);
        else if (p < 88) lat = TO - 1;
        else lat = NEVER;
        if (p >= 94 && idx < NS && slot_en_m[idx]) begin
          ab = $urandom_range(2, 4);
          w  = 1'b0;
        end
        a = {BASE[31:19], 3'(idx), 16'($urandom)};
        do_req(a, w, d, 4'($urandom), lat, $urandom, ab);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
